// File: rtl/countdown_timer.sv
// Countdown timer: BCD mm:ss.t count with a 10 Hz prescaler, run/pause control and a blinking alarm.
module countdown_timer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BLINK_TICKS = 5
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic       i_run,
    input  logic [3:0] i_pre_min_tens,
    input  logic [3:0] i_pre_min,
    input  logic [3:0] i_pre_sec_tens,
    input  logic [3:0] i_pre_sec,
    output logic [3:0] o_tenth,
    output logic [3:0] o_sec,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min,
    output logic [3:0] o_min_tens,
    output logic [1:0] o_state,
    output logic       o_tick,
    output logic       o_done,
    output logic       o_alarm
);

    localparam int unsigned TICK_DIV = CLK_HZ / 10;
    localparam int unsigned PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BL_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned DIG_W    = 4;

    localparam logic [PS_W-1:0]  PS_MAX = PS_W'(TICK_DIV - 1);
    localparam logic [BL_W-1:0]  BL_MAX = BL_W'(BLINK_TICKS - 1);
    localparam logic [DIG_W-1:0] NINE   = DIG_W'(9);
    localparam logic [DIG_W-1:0] FIVE   = DIG_W'(5);
    localparam logic [DIG_W-1:0] ONE    = DIG_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RUNNING = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t           state_q, state_nx;
    logic [PS_W-1:0]  ps_q, ps_nx;
    logic [BL_W-1:0]  bl_q, bl_nx;
    logic [DIG_W-1:0] t_nx, s_nx, st_nx, m_nx, mt_nx;
    logic             tick_nx, done_nx, alarm_nx;

    // Working copies for the borrow chain and preset clamping
    logic [DIG_W-1:0] dt, ds, dst, dm, dmt;
    logic [DIG_W-1:0] pmt, pm, pst, psec;
    logic             at_tick;

    function automatic logic [DIG_W-1:0] clamp(input logic [DIG_W-1:0] d, input logic [DIG_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign o_state = state_q;

    // State, prescaler, blink counter and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            ps_q       <= '0;
            bl_q       <= '0;
            o_tenth    <= '0;
            o_sec      <= '0;
            o_sec_tens <= '0;
            o_min      <= '0;
            o_min_tens <= '0;
            o_tick     <= 1'b0;
            o_done     <= 1'b0;
            o_alarm    <= 1'b0;
        end else begin
            state_q    <= state_nx;
            ps_q       <= ps_nx;
            bl_q       <= bl_nx;
            o_tenth    <= t_nx;
            o_sec      <= s_nx;
            o_sec_tens <= st_nx;
            o_min      <= m_nx;
            o_min_tens <= mt_nx;
            o_tick     <= tick_nx;
            o_done     <= done_nx;
            o_alarm    <= alarm_nx;
        end
    end

    // Next-state, count and alarm logic; load wins over run and tick
    always_comb begin
        state_nx = state_q;
        ps_nx    = ps_q;
        bl_nx    = bl_q;
        t_nx     = o_tenth;
        s_nx     = o_sec;
        st_nx    = o_sec_tens;
        m_nx     = o_min;
        mt_nx    = o_min_tens;
        alarm_nx = o_alarm;
        at_tick  = (ps_q == PS_MAX);

        pmt  = clamp(i_pre_min_tens, FIVE);
        pm   = clamp(i_pre_min, NINE);
        pst  = clamp(i_pre_sec_tens, FIVE);
        psec = clamp(i_pre_sec, NINE);

        // BCD decrement by one tenth with borrow ripple
        dt  = o_tenth;
        ds  = o_sec;
        dst = o_sec_tens;
        dm  = o_min;
        dmt = o_min_tens;
        if (o_tenth != '0) begin
            dt = o_tenth - ONE;
        end else begin
            dt = NINE;
            if (o_sec != '0) begin
                ds = o_sec - ONE;
            end else begin
                ds = NINE;
                if (o_sec_tens != '0) begin
                    dst = o_sec_tens - ONE;
                end else begin
                    dst = FIVE;
                    if (o_min != '0) begin
                        dm = o_min - ONE;
                    end else begin
                        dm  = NINE;
                        dmt = o_min_tens - ONE;
                    end
                end
            end
        end

        if (i_load) begin
            t_nx     = '0;
            s_nx     = psec;
            st_nx    = pst;
            m_nx     = pm;
            mt_nx    = pmt;
            ps_nx    = '0;
            bl_nx    = '0;
            alarm_nx = 1'b0;
            state_nx = (|{pmt, pm, pst, psec}) ? S_ARMED : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_nx = S_IDLE;
                end
                S_ARMED: begin
                    if (i_run) state_nx = S_RUNNING;
                end
                S_RUNNING: begin
                    if (!i_run) begin
                        state_nx = S_ARMED;
                    end else begin
                        ps_nx = at_tick ? '0 : ps_q + PS_W'(1);
                        if (!(|{o_min_tens, o_min, o_sec_tens, o_sec, o_tenth})) begin
                            // Defensive: never decrement from zero
                            state_nx = S_EXPIRED;
                            alarm_nx = 1'b1;
                            bl_nx    = '0;
                        end else if (at_tick) begin
                            t_nx  = dt;
                            s_nx  = ds;
                            st_nx = dst;
                            m_nx  = dm;
                            mt_nx = dmt;
                            if (!(|{dmt, dm, dst, ds, dt})) begin
                                state_nx = S_EXPIRED;
                                alarm_nx = 1'b1;
                                bl_nx    = '0;
                            end
                        end
                    end
                end
                S_EXPIRED: begin
                    if (!i_run) begin
                        state_nx = S_IDLE;
                        alarm_nx = 1'b0;
                    end else begin
                        ps_nx = at_tick ? '0 : ps_q + PS_W'(1);
                        if (at_tick) begin
                            if (bl_q == BL_MAX) begin
                                bl_nx    = '0;
                                alarm_nx = ~o_alarm;
                            end else begin
                                bl_nx = bl_q + BL_W'(1);
                            end
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end

        done_nx = (state_nx == S_EXPIRED);
        tick_nx = ((state_nx == S_RUNNING) || (state_nx == S_EXPIRED)) && (ps_nx == PS_MAX);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer at CLK_HZ=100 (ten cycles per tick), BLINK_TICKS=5.
module tb_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       run;
    logic [3:0] p_mt, p_m, p_st, p_s;
    logic [3:0] o_tenth, o_sec, o_sec_tens, o_min, o_min_tens;
    logic [1:0] o_state;
    logic       o_tick, o_done, o_alarm;

    int checks = 0;
    int errors = 0;
    int prod   = 0;
    int used   = 0;

    countdown_timer #(.CLK_HZ(100), .BLINK_TICKS(5)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_load        (load),
        .i_run         (run),
        .i_pre_min_tens(p_mt),
        .i_pre_min     (p_m),
        .i_pre_sec_tens(p_st),
        .i_pre_sec     (p_s),
        .o_tenth       (o_tenth),
        .o_sec         (o_sec),
        .o_sec_tens    (o_sec_tens),
        .o_min         (o_min),
        .o_min_tens    (o_min_tens),
        .o_state       (o_state),
        .o_tick        (o_tick),
        .o_done        (o_done),
        .o_alarm       (o_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       run;
        logic [3:0] pmt, pm, pst, ps;
        int         cycles;
        logic [1:0] st;
        logic [31:0] dig;
        logic       done;
        logic       alarm;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dig();
        return {12'h0, o_min_tens, o_min, o_sec_tens, o_sec, o_tenth};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One edge, tallying cycles spent running with run asserted
    task automatic pstep();
        if (o_state == 2'd2 && run) prod++;
        step();
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        used = 0;
        while (o_state != s && used < budget) begin
            pstep();
            used++;
        end
    endtask

    task automatic set_preset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        p_mt = a; p_m = b; p_st = c; p_s = d;
    endtask

    initial begin
        // load run  mt    m     st    s     cyc state dig          done alarm
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hA, 4'hF, 1,  2'd1, 32'h50590, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5,  2'd1, 32'h50590, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'h3, 4'hC, 4'h2, 4'hB, 1,  2'd1, 32'h39290, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1,  2'd0, 32'h00000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3,  2'd0, 32'h00000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1,  2'd1, 32'h10000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1,  2'd2, 32'h10000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 10, 2'd2, 32'h09599, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 10, 2'd2, 32'h09598, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3,  2'd1, 32'h09598, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 4'h0, 1,  2'd1, 32'h00100, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 11, 2'd2, 32'h00099, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1,  2'd0, 32'h00000, 1'b0, 1'b0};

        // Reset held while inputs toggle
        rst_n = 1'b0;
        load  = 1'b0;
        run   = 1'b0;
        set_preset(4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            load = 1'($urandom);
            run  = 1'($urandom);
            set_preset(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            step();
            chk($sformatf("reset_hold%0d", i), {o_state, o_tick, o_done, o_alarm, dig()}, 32'h0);
        end
        #4;
        rst_n = 1'b1;
        load  = 1'b0;
        run   = 1'b1;
        repeat (3) step();
        chk("post_reset_idle", {o_state, o_tick, o_done, o_alarm, dig()}, 32'h0);
        run = 1'b0;

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            load = vecs[v].load;
            run  = vecs[v].run;
            set_preset(vecs[v].pmt, vecs[v].pm, vecs[v].pst, vecs[v].ps);
            repeat (vecs[v].cycles) step();
            chk($sformatf("vec%0d_state", v), 32'(o_state), 32'(vecs[v].st));
            chk($sformatf("vec%0d_digits", v), dig(), vecs[v].dig);
            chk($sformatf("vec%0d_done", v), 32'(o_done), 32'(vecs[v].done));
            chk($sformatf("vec%0d_alarm", v), 32'(o_alarm), 32'(vecs[v].alarm));
        end
        load = 1'b0;
        run  = 1'b0;

        // Full 00:01 run: tick timing and expiry
        load = 1'b1;
        set_preset(4'h0, 4'h0, 4'h0, 4'h1);
        step();
        load = 1'b0;
        run  = 1'b1;
        step();
        chk("b_running", 32'(o_state), 32'd2);
        repeat (8) step();
        chk("b_no_tick_early", 32'(o_tick), 32'd0);
        step();
        chk("b_tick_pulse", 32'(o_tick), 32'd1);
        chk("b_before_tick", dig(), 32'h00010);
        step();
        chk("b_tick_low", 32'(o_tick), 32'd0);
        chk("b_first_tick", dig(), 32'h00009);
        wait_state(2'd3, 200);
        chk("b_expiry_cycles", 32'(used), 32'd90);
        chk("b_expired_digits", dig(), 32'h0);
        chk("b_done", 32'(o_done), 32'd1);
        chk("b_alarm", 32'(o_alarm), 32'd1);

        // Pause mid-count and resume
        run  = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        prod = 0;
        run  = 1'b1;
        repeat (37) pstep();
        chk("c_prod_before_pause", 32'(prod), 32'd36);
        chk("c_digits_before_pause", dig(), 32'h00007);
        run = 1'b0;
        repeat (50) pstep();
        chk("c_paused_state", 32'(o_state), 32'd1);
        chk("c_paused_digits", dig(), 32'h00007);
        run = 1'b1;
        wait_state(2'd3, 200);
        chk("c_reached_expired", 32'(o_state), 32'd3);
        chk("c_total_running", 32'(prod), 32'd100);

        // Alarm blink in EXPIRED, then acknowledge
        used = 0;
        while (o_alarm == 1'b1 && used < 200) begin
            step();
            used++;
        end
        chk("d_blink_off_cycles", 32'(used), 32'd50);
        used = 0;
        while (o_alarm == 1'b0 && used < 200) begin
            step();
            used++;
        end
        chk("d_blink_on_cycles", 32'(used), 32'd50);
        chk("d_still_expired", {o_state, o_done, dig()}, {2'd3, 1'b1, 32'h0});
        run = 1'b0;
        step();
        chk("d_ack", {o_state, o_done, o_alarm, dig()}, 32'h0);

        // Load collides with a tick while running
        load = 1'b1;
        set_preset(4'h0, 4'h0, 4'h0, 4'h2);
        step();
        load = 1'b0;
        run  = 1'b1;
        used = 0;
        while (o_tick != 1'b1 && used < 50) begin
            step();
            used++;
        end
        chk("e_tick_wait", 32'(used), 32'd10);
        load = 1'b1;
        set_preset(4'hF, 4'h0, 4'hA, 4'hF);
        step();
        load = 1'b0;
        chk("e_load_state", 32'(o_state), 32'd1);
        chk("e_load_digits", dig(), 32'h50590);
        chk("e_load_tick", 32'(o_tick), 32'd0);
        step();
        chk("e_resume_state", 32'(o_state), 32'd2);
        chk("e_resume_digits", dig(), 32'h50590);

        // Asynchronous reset mid-count
        repeat (25) step();
        chk("f_counting", {o_state, dig()}, {2'd2, 32'h50588});
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_async_reset", {o_state, o_tick, o_done, o_alarm, dig()}, 32'h0);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        chk("f_stays_idle", {o_state, dig()}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
